alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised ALU for the SAP datapath: arithmetic/logic between A and B registers with
//  registered result, flag register (C,Z,N,V) and bus drive gated by an output enable.
//  Adds carry-chained ops and an iterative shift-add multiply with start/busy/valid handshake.
//  Sits between the A/B registers and the shared W bus; flags feed the controller for jumps.
// PARAMETERS
//  WIDTH     8   data width of operands, result and bus (>=4)
// PORTS
//  clk_i       in   1        system clock, all state on rising edge
//  rstn_i      in   1        asynchronous, active-low reset
//  a_i         in   WIDTH    operand A (accumulator)
//  b_i         in   WIDTH    operand B
//  op_i        in   3        operation, sampled with start_i (codes in alu_pkg)
//  start_i     in   1        launch op; ignored while busy_o=1
//  flag_we_i   in   1        sampled with start_i; 1 = update flags on completion
//  out_en_i    in   1        1 = drive result onto bus_o
//  res_o       out  WIDTH    registered result (low half of product for MUL)
//  res_hi_o    out  WIDTH    high half of product (MUL), 0 for other ops
//  bus_o       out  WIDTH    out_en_i ? res_o : 0 (zero when idle, for OR-bus)
//  flags_o     out  4        {C,Z,N,V} flag register
//  busy_o      out  1        multiply in progress
//  valid_o     out  1        1-cycle pulse: res_o/flags_o updated this cycle
// BEHAVIOUR
//  Reset: res_o, res_hi_o, flags_o, busy_o, valid_o, multiplier state = 0 immediately.
//  Ops: 000 ADD, 001 SUB, 010 ADC (A+B+C), 011 SBB (A-B-C), 100 AND, 101 OR, 110 XOR, 111 MUL.
//  Single-cycle ops: start_i at edge n -> res_o and valid_o=1 after edge n+1 (1-cycle latency).
//  Arithmetic at WIDTH+1 bits; C = carry-out for ADD/ADC, C = borrow for SUB/SBB (A<B+cin).
//  V = signed overflow (2's complement); N = res MSB; Z = (result==0); logic ops: C=V=0.
//  ADC/SBB use the flag C held at the start cycle. Wrap-around modulo 2^WIDTH, no saturation.
//  MUL (unsigned): FSM IDLE -> RUN (WIDTH cycles, one shift-add per cycle) -> DONE -> IDLE.
//   busy_o=1 for cycles n+1..n+WIDTH; valid_o=1 at cycle n+WIDTH+1, busy_o=0 that cycle.
//   Product = {res_hi_o,res_o}; Z = full product==0; C=V=(res_hi_o!=0); N = res_o MSB.
//  Operands latched at start; a_i/b_i changes during RUN have no effect.
//  start_i while busy_o=1 ignored (no queueing); start_i in the DONE cycle is accepted.
//  flag_we_i=0: flags_o unchanged, result still written. res_o holds until next completion.
//  Reset asserted mid-MUL aborts; no valid_o pulse; returns to IDLE with all outputs 0.
//  bus_o is combinational from res_o and out_en_i only; no other path to the bus.
// STRUCTURE
//  alu_pkg: WIDTH-independent op code localparams (OP_ADD..OP_MUL), flag bit indices
//   (FLG_C=3,FLG_Z=2,FLG_N=1,FLG_V=0), FSM state encoding.
//  Sub-module alu_mul_seq: shift-add multiplier core (start, a, b -> busy, done, product
//   2*WIDTH); alu_seq owns op decode, single-cycle datapath, flag register, output mux.
// TESTING (WIDTH=8)
//  ADD 0xFF+0x01, flag_we=1 -> res 0x00, C=1 Z=1 N=0 V=0, valid one cycle after start.
//  SUB 0x10-0x20 -> res 0xF0, C=1 N=1; then SBB 0x05-0x01 with C=1 -> res 0x03, C=0.
//  ADD 0x7F+0x01 -> res 0x80, V=1 N=1 C=0; out_en_i=0 -> bus_o=0x00, =1 -> bus_o=0x80.
//  MUL 0xFF*0xFF -> busy 8 cycles, valid at cycle 9, {hi,lo}=0xFE01, C=V=1; start during
//   busy ignored, result unchanged.
//  MUL 0x0F*0x11 with flag_we=0 -> {hi,lo}=0x00FF, flags unchanged from prior op.
//  Assert rstn_i=0 at RUN cycle 4 -> busy_o, res_o, flags_o = 0 at once, no valid pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the SAP ALU: op codes, flag bit positions and multiplier FSM states.
package alu_pkg;

  // Operation codes carried on op_i
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Bit positions inside the {C,Z,N,V} flag register
  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_V = 0;

  // Shift-add multiplier sequencing
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Assemble a flag word so every producer uses the same bit placement
  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   step;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> RUN (WIDTH steps) -> DONE -> IDLE, DONE may relaunch directly
  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == LAST) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // One step: add multiplicand into the high half when the current LSB is set, then shift right
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    step = {sum, acc[WIDTH-1:0]};
  end

  // The final step's value is presented with done so the parent can register it
  // in the same edge that moves this FSM into DONE.
  assign busy    = (state == MUL_RUN);
  assign done    = busy && (cnt == LAST);
  assign product = step[2*WIDTH:1];

  // Operand latch and accumulator; multiplier (b) is shifted out of the low half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state != MUL_RUN && start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == MUL_RUN) begin
      acc   <= step[2*WIDTH:1];
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// SAP ALU: single-cycle arithmetic/logic, sequential multiply, flag register and gated bus drive.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             start_i,
  input  logic             flag_we_i,
  input  logic             out_en_i,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] bus_o,
  output logic [3:0]       flags_o,
  output logic             busy_o,
  output logic             valid_o
);

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_fwe;
  logic [2*WIDTH-1:0] mul_product;

  logic               use_cin;
  logic [WIDTH:0]     arith;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic               write;
  logic [WIDTH-1:0]   res_nxt;
  logic [WIDTH-1:0]   hi_nxt;
  logic [3:0]         flags_nxt;

  assign accept    = start_i && !mul_busy;
  assign mul_start = accept && (op_i == OP_MUL);
  assign busy_o    = mul_busy;
  assign bus_o     = out_en_i ? res_o : '0;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .start   (mul_start),
    .a       (a_i),
    .b       (b_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath, evaluated at WIDTH+1 bits so bit WIDTH is carry/borrow
  always_comb begin
    arith   = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    use_cin = ((op_i == OP_ADC) || (op_i == OP_SBB)) && flags_o[FLG_C];
    case (op_i)
      OP_ADD, OP_ADC: begin
        arith   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, use_cin};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        arith   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, use_cin};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
        alu_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      default: alu_res = '0;
    endcase
  end

  // Select which producer updates result/flags this edge; both can never fire together
  always_comb begin
    write     = 1'b0;
    res_nxt   = res_o;
    hi_nxt    = res_hi_o;
    flags_nxt = flags_o;
    if (mul_done) begin
      write   = 1'b1;
      res_nxt = mul_product[WIDTH-1:0];
      hi_nxt  = mul_product[2*WIDTH-1:WIDTH];
      if (mul_fwe)
        flags_nxt = pack_flags(|hi_nxt, (mul_product == '0), res_nxt[WIDTH-1], |hi_nxt);
    end else if (accept && (op_i != OP_MUL)) begin
      write   = 1'b1;
      res_nxt = alu_res;
      hi_nxt  = '0;
      if (flag_we_i)
        flags_nxt = pack_flags(alu_c, (alu_res == '0), alu_res[WIDTH-1], alu_v);
    end
  end

  // Result, flag and completion registers; flag_we is captured at multiply launch
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res_o    <= '0;
      res_hi_o <= '0;
      flags_o  <= '0;
      valid_o  <= 1'b0;
      mul_fwe  <= 1'b0;
    end else begin
      valid_o <= write;
      flags_o <= flags_nxt;
      if (write) begin
        res_o    <= res_nxt;
        res_hi_o <= hi_nxt;
      end
      if (mul_start) mul_fwe <= flag_we_i;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized check of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn_i;
  logic [W-1:0] a_i, b_i;
  logic [2:0]   op_i;
  logic         start_i, flag_we_i, out_en_i;
  logic [W-1:0] res_o, res_hi_o, bus_o;
  logic [3:0]   flags_o;
  logic         busy_o, valid_o;

  int tests = 0;
  int fails = 0;

  int         m_res   = 0;
  int         m_hi    = 0;
  logic [3:0] m_flags = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .op_i      (op_i),
    .start_i   (start_i),
    .flag_we_i (flag_we_i),
    .out_en_i  (out_en_i),
    .res_o     (res_o),
    .res_hi_o  (res_hi_o),
    .bus_o     (bus_o),
    .flags_o   (flags_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic void ref_op(input logic [2:0] op, input int a, input int b, input bit cin,
                                 output int r, output int hi, output logic [3:0] f);
    int s, sa, sb, ss, ci;
    bit c, v, z;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    ci = ((op == OP_ADC) || (op == OP_SBB)) ? int'(cin) : 0;
    c = 0; v = 0; hi = 0; s = 0; r = 0;
    case (op)
      OP_ADD, OP_ADC: begin
        s = a + b + ci; ss = sa + sb + ci;
        c = (s > 255); v = (ss > 127) || (ss < -128); r = s % 256;
      end
      OP_SUB, OP_SBB: begin
        s = a - b - ci; ss = sa - sb - ci;
        c = (s < 0); v = (ss > 127) || (ss < -128); r = s & 255;
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: begin
        s = a * b; r = s % 256; hi = s / 256; c = (hi != 0); v = c;
      end
    endcase
    z = (op == OP_MUL) ? (s == 0) : (r == 0);
    f = {c, z, (r >= 128), v};
  endfunction

  // Launch one op and check its completion; poke issues a start mid-multiply that must be ignored
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit fwe, input bit poke, input bit oe);
    int r, hi, prev_res;
    logic [3:0] f;
    prev_res = m_res;
    ref_op(op, int'(a), int'(b), m_flags[3], r, hi, f);
    op_i = op; a_i = a; b_i = b; flag_we_i = fwe; out_en_i = oe; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (op == OP_MUL) begin
      a_i = 8'($urandom); b_i = 8'($urandom);
      for (int i = 0; i < W; i++) begin
        check("mul_busy", busy_o, 1);
        check("mul_valid_low", valid_o, 0);
        check("mul_res_hold", res_o, prev_res);
        if (poke && i == 2) begin
          op_i = OP_ADD; a_i = 8'h00; b_i = 8'h00; start_i = 1'b1;
        end else begin
          start_i = 1'b0;
        end
        @(posedge clk); #1;
      end
      start_i = 1'b0;
    end
    m_res = r; m_hi = hi;
    if (fwe) m_flags = f;
    check("done_valid", valid_o, 1);
    check("done_busy", busy_o, 0);
    check("res", res_o, m_res);
    check("res_hi", res_hi_o, m_hi);
    check("flags", flags_o, m_flags);
    check("bus", bus_o, oe ? m_res : 0);
  endtask

  initial begin
    rstn_i = 1'b1; a_i = '0; b_i = '0; op_i = '0;
    start_i = 1'b0; flag_we_i = 1'b0; out_en_i = 1'b1;
    #2 rstn_i = 1'b0;
    #3;
    check("rst_res", res_o, 0);
    check("rst_hi", res_hi_o, 0);
    check("rst_flags", flags_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_bus", bus_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn_i = 1'b1;
    @(posedge clk); #1;

    do_op(OP_ADD, 8'hFF, 8'h01, 1, 0, 1);
    check("add_ff01_res", res_o, 8'h00);
    check("add_ff01_flags", flags_o, 4'b1100);
    @(posedge clk); #1;
    check("valid_one_cycle", valid_o, 0);
    check("res_holds", res_o, 8'h00);

    do_op(OP_SUB, 8'h10, 8'h20, 1, 0, 1);
    check("sub_res", res_o, 8'hF0);
    check("sub_flags", flags_o, 4'b1010);
    do_op(OP_SBB, 8'h05, 8'h01, 1, 0, 1);
    check("sbb_res", res_o, 8'h03);
    check("sbb_flags", flags_o, 4'b0000);

    do_op(OP_ADD, 8'h7F, 8'h01, 1, 0, 0);
    check("ovf_flags", flags_o, 4'b0011);
    check("bus_off", bus_o, 8'h00);
    out_en_i = 1'b1; #1;
    check("bus_on", bus_o, 8'h80);

    do_op(OP_MUL, 8'hFF, 8'hFF, 1, 1, 1);
    check("mul_ffff", {res_hi_o, res_o}, 16'hFE01);
    check("mul_ffff_flags", flags_o, 4'b1001);
    do_op(OP_MUL, 8'h0F, 8'h11, 0, 0, 1);
    check("mul_0f11", {res_hi_o, res_o}, 16'h00FF);
    check("mul_nofwe_flags", flags_o, 4'b1001);

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    do_op(OP_ADD, 8'h7F, 8'h01, 1, 0, 1);
    op_i = OP_MUL; a_i = 8'hFF; b_i = 8'hFF; flag_we_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", busy_o, 1);
    rstn_i = 1'b0; #1;
    check("abort_busy", busy_o, 0);
    check("abort_res", res_o, 0);
    check("abort_hi", res_hi_o, 0);
    check("abort_flags", flags_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_bus", bus_o, 0);
    m_res = 0; m_hi = 0; m_flags = '0;
    @(posedge clk); #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_abort_valid", valid_o, 0);
      check("post_abort_busy", busy_o, 0);
    end
    do_op(OP_XOR, 8'hA5, 8'h5A, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
